// File: rtl/axis_ingress_buf_pkg.sv
// Shared types and default parameters for the ingress buffer slice.
package axis_ingress_pkg;

    typedef enum logic {
        ST_PASS    = 1'b0,
        ST_DISCARD = 1'b1
    } ingress_state_e;

    localparam int TRUNC_CNT_W     = 16;
    localparam int DEF_DATA_WIDTH  = 64;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_MAX_BEATS   = 190;

endpackage

// File: rtl/axis_ingress_buf_if.sv
// AXI4-Stream bundle with the start-of-frame and truncation sidebands.
interface axis_ingress_buf_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic                    tsof;
    logic                    ttrunc;

    modport master (output tdata, tkeep, tvalid, tlast, tsof, ttrunc, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tsof, ttrunc, output tready);
endinterface

// File: rtl/axis_ingress_buf_fifo.sv
// Purpose: generic synchronous FIFO with registered write-ready and occupancy level.
// Latency: one cycle from write to head visibility; no bypass.
// Backpressure: wr_rdy is registered (next level < DEPTH), independent of rd_rdy combinationally.
module axis_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_vld,
    input  logic [WIDTH-1:0]           wr_dat,
    output logic                       wr_rdy,
    output logic                       rd_vld,
    output logic [WIDTH-1:0]           rd_dat,
    input  logic                       rd_rdy,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;
    logic [LVL_W-1:0] level_nxt;

    assign wr_en     = wr_vld && wr_rdy;
    assign rd_en     = rd_vld && rd_rdy;
    assign rd_vld    = (level != '0);
    assign rd_dat    = mem[rd_ptr];
    assign level_nxt = level + LVL_W'(wr_en) - LVL_W'(rd_en);

    // Pointers are exactly log2(DEPTH) wide, so they wrap for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            wr_rdy <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            level  <= level_nxt;
            wr_rdy <= (level_nxt < LVL_W'(DEPTH));
        end
    end

endmodule

// File: rtl/axis_ingress_buf.sv
// Purpose: buffered AXIS ingress; marks SOF, truncates frames longer than MAX_BEATS, counts truncations.
// Latency: one cycle from upstream accept to m_axis head; one beat/cycle sustained.
// Backpressure: s_axis.tready is registered FIFO space, forced high while discarding excess beats.
module axis_ingress_buf
    import axis_ingress_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int MAX_BEATS  = DEF_MAX_BEATS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    axis_ingress_buf_if.slave          s_axis,
    axis_ingress_buf_if.master         m_axis,
    output logic                       beat_accept,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic [TRUNC_CNT_W-1:0]     trunc_count
);
    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] tdata;
        logic [KEEP_W-1:0]     tkeep;
        logic                  last;
        logic                  sof;
        logic                  trunc;
    } entry_t;

    ingress_state_e   state;
    logic [CNT_W-1:0] beat_cnt;
    logic             fifo_wr_rdy;
    logic             fifo_rd_vld;
    logic             at_limit;
    logic             wr_vld;
    entry_t           wr_entry;
    entry_t           rd_entry;

    assign s_axis.tready = fifo_wr_rdy || (state == ST_DISCARD);
    assign beat_accept   = s_axis.tvalid && s_axis.tready;
    assign at_limit      = (beat_cnt == CNT_LAST);
    assign wr_vld        = beat_accept && (state == ST_PASS);

    // A real tlast on the limit beat is a legal max-length frame, not a truncation.
    assign wr_entry.tdata = s_axis.tdata;
    assign wr_entry.tkeep = s_axis.tkeep;
    assign wr_entry.last  = s_axis.tlast || at_limit;
    assign wr_entry.sof   = (beat_cnt == '0);
    assign wr_entry.trunc = !s_axis.tlast && at_limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_PASS;
            beat_cnt    <= '0;
            trunc_count <= '0;
        end else if (beat_accept) begin
            case (state)
                ST_PASS: begin
                    if (s_axis.tlast) begin
                        beat_cnt <= '0;
                    end else if (at_limit) begin
                        beat_cnt <= '0;
                        state    <= ST_DISCARD;
                        if (trunc_count != '1) trunc_count <= trunc_count + 1'b1;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                ST_DISCARD: begin
                    if (s_axis.tlast) state <= ST_PASS;
                end
                default: state <= ST_PASS;
            endcase
        end
    end

    axis_sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (wr_vld),
        .wr_dat (wr_entry),
        .wr_rdy (fifo_wr_rdy),
        .rd_vld (fifo_rd_vld),
        .rd_dat (rd_entry),
        .rd_rdy (m_axis.tready),
        .level  (fifo_level)
    );

    assign m_axis.tvalid = fifo_rd_vld;
    assign m_axis.tdata  = rd_entry.tdata;
    assign m_axis.tkeep  = rd_entry.tkeep;
    assign m_axis.tlast  = rd_entry.last;
    assign m_axis.tsof   = rd_entry.sof;
    assign m_axis.ttrunc = rd_entry.trunc;

endmodule
